top_memoria: RTL
================

Name: top_memoria

Overview:
- Memory-access stage of the MIPS pipeline: the consumer of the EX/MEM latch that the execution stage drives.
- Performs loads and stores on an internal word-organised data RAM, including sub-word accesses via read-modify-write.
- Drives the MEM/WB latch and raises a stall request to upstream stages while a multi-cycle access is in flight.

Parameters:
WIDTH_DATA_MEM, 32, data word width in bits
CANT_REGISTROS, 32, register-file size; register index width R = clogb2(CANT_REGISTROS-1) = 5
CANT_BITS_ADDR, 11, RAM word-address bits; depth = 2^CANT_BITS_ADDR words
CANT_BITS_SELECT_BYTES_MEM_DATA, 2, access-size code width

Ports:
i_clock  in  1  clock; all state updates on the rising edge
i_soft_reset  in  1  synchronous, active-high reset
i_enable_pipeline  in  1  global step enable; no state change when 0
i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg  in  1 each  EX/MEM control
i_select_bytes_mem_datos  in  2  access size: 0 byte, 1 halfword, 2 or 3 word
i_load_unsigned  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
i_result  in  32  ALU result; byte address for memory ops
i_data_write_to_mem  in  32  store data
i_registro_destino  in  R  destination register
i_halt_detected  in  1  halt marker
o_RegWrite, o_MemtoReg, o_halt_detected  out  1 each  MEM/WB control
o_read_data  out  32  formatted load data
o_alu_result  out  32  passthrough of i_result
o_registro_destino  out  R  destination register
o_stall_request  out  1  combinational; equals (state != IDLE)

Behaviour:
- Reset (any state, i_soft_reset=1 at edge):
  - state <= IDLE; all outputs <= 0.
  - A pending RMW write is dropped.
  - RAM contents are not cleared.
- Address decode:
  - word index = i_result[CANT_BITS_ADDR+1:2]; lane = i_result[1:0].
  - Little-endian: lane 0 = bits 7:0.
  - Halfword uses lane[1] only; lane[0] is ignored. Word accesses ignore lane.
- MemWrite=1 and MemRead=1 together: treated as a store; MemRead is ignored.
- FSM states: IDLE, LOAD_WAIT, RMW_WAIT. Transitions and MEM/WB updates occur only at edges with i_enable_pipeline=1. With enable=0 every register, including the RAM read register, holds.
- IDLE, no memory op: MEM/WB <= inputs at the edge (1-cycle latency); o_read_data <= 0.
- IDLE, word store: RAM[word] <= i_data_write_to_mem; MEM/WB <= inputs at the same edge; stays IDLE; no stall.
- IDLE, load:
  - Capture request fields (address, size, unsigned, control, registro_destino, halt, result) into internal registers.
  - Issue a synchronous RAM read; go to LOAD_WAIT.
- LOAD_WAIT, next enabled edge:
  - Select lane from the RAM word; extend to 32 bits per captured i_load_unsigned.
  - o_read_data <= formatted data; remaining MEM/WB fields <= captured values; go to IDLE.
  - Load latency is 2 enabled cycles; o_stall_request=1 for exactly that one cycle.
- IDLE, byte/halfword store:
  - Capture fields including store data; issue RAM read; go to RMW_WAIT.
- RMW_WAIT, next enabled edge:
  - Merge: byte writes data[7:0] into the selected lane; halfword writes data[15:0] into the selected half; other bits are preserved.
  - Write the merged word; MEM/WB <= captured fields with o_read_data <= 0; go to IDLE.
- While in LOAD_WAIT or RMW_WAIT, all inputs are ignored. Upstream holds the next instruction stable because o_stall_request=1.
- Store followed immediately by a load to the same word: the load observes the stored value (the write completes before the read is issued).
- o_stall_request is never asserted in IDLE.

Test Plan:
1. Word store 0xDEADBEEF to address 0x10, then word load from 0x10 -> o_read_data=0xDEADBEEF two enabled edges after the load is presented; o_stall_request high for exactly 1 cycle.
2. Byte store 0xAB to address 0x11 over the word from test 1 -> RMW takes 2 cycles with 1 stall cycle; word load from 0x10 -> 0xDEADABEF.
3. Byte load from 0x11 (value 0xAB): i_load_unsigned=0 -> 0xFFFFFFAB; i_load_unsigned=1 -> 0x000000AB. Halfword store 0x8001 to 0x12, then signed halfword load -> 0xFFFF8001.
4. Non-memory op (RegWrite=1, result=0x1234, rd=7) -> next edge: o_alu_result=0x1234, o_registro_destino=7, o_RegWrite=1, o_read_data=0, no stall.
5. Load issued, then i_enable_pipeline=0 for 3 cycles -> state held in LOAD_WAIT, stall held at 1, outputs frozen; completes on the first enabled edge.
6. Reset asserted in RMW_WAIT -> outputs 0, IDLE, stall 0; the target word keeps its pre-RMW value.

Source files
------------

// File: rtl/top_memoria.sv
// -----------------------------------------------------------------------------
// top_memoria
// Memory-access stage of the MIPS pipeline. Consumes the EX/MEM latch, performs
// loads and stores on an internal word-organised data RAM (sub-word stores by
// read-modify-write) and drives the MEM/WB latch. Any access that needs a RAM
// read takes two enabled cycles and raises o_stall_request for the second one.
//
// Ports
//   i_clock                  clock, all state changes on the rising edge
//   i_soft_reset             synchronous active-high reset (RAM contents kept)
//   i_enable_pipeline        global step enable, nothing changes when low
//   i_RegWrite/i_MemRead/i_MemWrite/i_MemtoReg   EX/MEM control
//   i_select_bytes_mem_datos access size: 0 byte, 1 halfword, 2/3 word
//   i_load_unsigned          1 zero-extends sub-word loads, 0 sign-extends
//   i_result                 ALU result, byte address for memory ops
//   i_data_write_to_mem      store data
//   i_registro_destino       destination register
//   i_halt_detected          halt marker
//   o_RegWrite/o_MemtoReg/o_halt_detected       MEM/WB control
//   o_read_data              formatted load data (0 for non-loads)
//   o_alu_result             passthrough of i_result
//   o_registro_destino       destination register
//   o_stall_request          high while a two-cycle access is in flight
// -----------------------------------------------------------------------------
module top_memoria #(
  parameter int WIDTH_DATA_MEM                  = 32,
  parameter int CANT_REGISTROS                  = 32,
  parameter int CANT_BITS_ADDR                  = 11,
  parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 2
) (
  input  logic                                       i_clock,
  input  logic                                       i_soft_reset,
  input  logic                                       i_enable_pipeline,
  input  logic                                       i_RegWrite,
  input  logic                                       i_MemRead,
  input  logic                                       i_MemWrite,
  input  logic                                       i_MemtoReg,
  input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_bytes_mem_datos,
  input  logic                                       i_load_unsigned,
  input  logic [WIDTH_DATA_MEM-1:0]                  i_result,
  input  logic [WIDTH_DATA_MEM-1:0]                  i_data_write_to_mem,
  // $clog2(N) equals the bit count needed for index N-1
  input  logic [$clog2(CANT_REGISTROS)-1:0]          i_registro_destino,
  input  logic                                       i_halt_detected,
  output logic                                       o_RegWrite,
  output logic                                       o_MemtoReg,
  output logic                                       o_halt_detected,
  output logic [WIDTH_DATA_MEM-1:0]                  o_read_data,
  output logic [WIDTH_DATA_MEM-1:0]                  o_alu_result,
  output logic [$clog2(CANT_REGISTROS)-1:0]          o_registro_destino,
  output logic                                       o_stall_request
);

  localparam int W     = WIDTH_DATA_MEM;
  localparam int R     = $clog2(CANT_REGISTROS);
  localparam int SW    = CANT_BITS_SELECT_BYTES_MEM_DATA;
  localparam int AW    = CANT_BITS_ADDR;
  localparam int DEPTH = 1 << AW;

  localparam logic [SW-1:0] SZ_BYTE = SW'(0);
  localparam logic [SW-1:0] SZ_HALF = SW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WAIT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Data formatting helpers (little-endian, lane 0 = bits 7:0)
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] format_load(input logic [W-1:0]  word,
                                               input logic [SW-1:0] size,
                                               input logic [1:0]    lane,
                                               input logic          uns);
    logic [7:0]   b;
    logic [15:0]  h;
    logic [W-1:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    // Halfwords only look at lane[1]; an odd halfword address is rounded down.
    h = lane[1] ? word[31:16] : word[15:0];
    if (size == SZ_BYTE)
      r = uns ? {{(W-8){1'b0}}, b} : {{(W-8){b[7]}}, b};
    else if (size == SZ_HALF)
      r = uns ? {{(W-16){1'b0}}, h} : {{(W-16){h[15]}}, h};
    else
      r = word;
    return r;
  endfunction

  function automatic logic [W-1:0] merge_store(input logic [W-1:0]  word,
                                               input logic [15:0]   data,
                                               input logic [SW-1:0] size,
                                               input logic [1:0]    lane);
    logic [W-1:0] r;
    r = word;
    if (size == SZ_BYTE) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else begin
      if (lane[1]) r[31:16] = data;
      else         r[15:0]  = data;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t state, state_next;

  // Request captured when a two-cycle access starts; inputs are ignored after.
  logic [W-1:0]  cap_result;
  logic [SW-1:0] cap_size;
  logic          cap_unsigned;
  logic          cap_regwrite;
  logic          cap_memtoreg;
  logic [R-1:0]  cap_rd;
  logic          cap_halt;
  logic [15:0]   cap_wdata;    // only the low half can reach a sub-word store
  logic          cap_en;

  // MEM/WB next values
  logic          regwrite_next;
  logic          memtoreg_next;
  logic          halt_next;
  logic [W-1:0]  read_data_next;
  logic [W-1:0]  alu_next;
  logic [R-1:0]  rd_next;

  // RAM
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  ram_q;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [W-1:0]  ram_wdata;

  logic [AW-1:0] word_idx;
  logic [AW-1:0] cap_word;
  logic [1:0]    cap_lane;
  logic          is_word_size;

  assign word_idx     = i_result[AW+1:2];
  assign cap_word     = cap_result[AW+1:2];
  assign cap_lane     = cap_result[1:0];
  assign is_word_size = (i_select_bytes_mem_datos != SZ_BYTE) &&
                        (i_select_bytes_mem_datos != SZ_HALF);

  assign o_stall_request = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and MEM/WB decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next     = state;
    regwrite_next  = o_RegWrite;
    memtoreg_next  = o_MemtoReg;
    halt_next      = o_halt_detected;
    read_data_next = o_read_data;
    alu_next       = o_alu_result;
    rd_next        = o_registro_destino;
    cap_en         = 1'b0;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    ram_waddr      = word_idx;
    ram_raddr      = word_idx;
    ram_wdata      = i_data_write_to_mem;

    case (state)
      IDLE: begin
        // MemWrite wins when both MemWrite and MemRead are set.
        if (i_MemWrite && is_word_size) begin
          ram_we         = 1'b1;
          regwrite_next  = i_RegWrite;
          memtoreg_next  = i_MemtoReg;
          halt_next      = i_halt_detected;
          read_data_next = '0;
          alu_next       = i_result;
          rd_next        = i_registro_destino;
        end else if (i_MemWrite) begin
          cap_en     = 1'b1;
          ram_re     = 1'b1;
          state_next = RMW_WAIT;
        end else if (i_MemRead) begin
          cap_en     = 1'b1;
          ram_re     = 1'b1;
          state_next = LOAD_WAIT;
        end else begin
          regwrite_next  = i_RegWrite;
          memtoreg_next  = i_MemtoReg;
          halt_next      = i_halt_detected;
          read_data_next = '0;
          alu_next       = i_result;
          rd_next        = i_registro_destino;
        end
      end

      LOAD_WAIT: begin
        regwrite_next  = cap_regwrite;
        memtoreg_next  = cap_memtoreg;
        halt_next      = cap_halt;
        read_data_next = format_load(ram_q, cap_size, cap_lane, cap_unsigned);
        alu_next       = cap_result;
        rd_next        = cap_rd;
        state_next     = IDLE;
      end

      RMW_WAIT: begin
        ram_we         = 1'b1;
        ram_waddr      = cap_word;
        ram_wdata      = merge_store(ram_q, cap_wdata, cap_size, cap_lane);
        regwrite_next  = cap_regwrite;
        memtoreg_next  = cap_memtoreg;
        halt_next      = cap_halt;
        read_data_next = '0;
        alu_next       = cap_result;
        rd_next        = cap_rd;
        state_next     = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, capture and MEM/WB registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    if (i_soft_reset) begin
      state              <= IDLE;
      o_RegWrite         <= 1'b0;
      o_MemtoReg         <= 1'b0;
      o_halt_detected    <= 1'b0;
      o_read_data        <= '0;
      o_alu_result       <= '0;
      o_registro_destino <= '0;
      cap_result         <= '0;
      cap_size           <= '0;
      cap_unsigned       <= 1'b0;
      cap_regwrite       <= 1'b0;
      cap_memtoreg       <= 1'b0;
      cap_rd             <= '0;
      cap_halt           <= 1'b0;
      cap_wdata          <= '0;
    end else if (i_enable_pipeline) begin
      state              <= state_next;
      o_RegWrite         <= regwrite_next;
      o_MemtoReg         <= memtoreg_next;
      o_halt_detected    <= halt_next;
      o_read_data        <= read_data_next;
      o_alu_result       <= alu_next;
      o_registro_destino <= rd_next;
      if (cap_en) begin
        cap_result   <= i_result;
        cap_size     <= i_select_bytes_mem_datos;
        cap_unsigned <= i_load_unsigned;
        cap_regwrite <= i_RegWrite;
        cap_memtoreg <= i_MemtoReg;
        cap_rd       <= i_registro_destino;
        cap_halt     <= i_halt_detected;
        cap_wdata    <= i_data_write_to_mem[15:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data RAM with registered read port
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    // NOTE: the array and its read register have no reset; contents survive a
    // soft reset, and only the write strobe is blocked so a pending
    // read-modify-write is dropped.
    if (i_enable_pipeline && !i_soft_reset) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_q <= mem[ram_raddr];
    end
  end

endmodule
